wr_stream_adapter: RTL

Write-side front end of the asynchronous FIFO, in the write clock domain, directly upstream of the write-pointer logic. It accepts a valid/ready stream from the producer, holds words in a 2-entry skid buffer, and drives `wr_en`/`wr_data` into the FIFO only when the FIFO's registered `full` flag is low. It also keeps write and stall statistics for debug.

---
 rtl/wr_stream_adapter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wr_stream_adapter.sv
// Write-side stream adapter for the asynchronous FIFO.
// Accepts a valid/ready stream into a two-entry FIFO-ordered skid buffer
// and presents the head word to the FIFO whenever its registered full
// flag is low. Also keeps a wrapping write counter and a saturating
// stall counter for debug.
module wr_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  head_valid;
    logic                  push;
    logic                  pop;
    logic                  load_head_in;
    logic                  load_tail_in;
    logic                  load_head_tail;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    assign head_valid = (state != EMPTY);
    assign push       = s_valid & s_ready;
    assign pop        = head_valid & ~full;
    assign wr_en      = pop;
    assign wr_data    = head;

    // Next-state and buffer load selection from the push/pop events.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_tail_in   = 1'b0;
        load_head_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt    = TWO;
                    load_tail_in = 1'b1;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    load_head_in = 1'b1;
                end
            end
            TWO: begin
                // s_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Control state, registered ready and statistics; reset dominates.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state       <= EMPTY;
            s_ready     <= 1'b0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt != TWO);
            if (pop) begin
                wr_count <= wr_count + CNT_WIDTH'(1);
            end
            if (head_valid && full) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

    // Data registers carry no reset; their contents are qualified by state.
    always_ff @(posedge wr_clk) begin
        if (load_head_in) begin
            head <= s_data;
        end else if (load_head_tail) begin
            head <= tail;
        end
        if (load_tail_in) begin
            tail <= s_data;
        end
    end

endmodule
